// File: rtl/output_decoder_if.sv
// Symbol-serial control link between the request sender and output_decoder.
// One request/ack pair per symbol, plus the committed channel commands.
interface output_decoder_if;
    logic Fs;
    logic Fe;
    logic Fd;
    logic X0;
    logic One;
    logic Zero;
    logic Fs_ack;
    logic Fe_ack;
    logic Fd_ack;
    logic X0_ack;
    logic one_ack;
    logic zero_ack;
    logic Ch1_Up;
    logic Ch1_Down;
    logic Ch2_Up;
    logic Ch2_Down;

    // Sender side: raises requests, watches acks and the committed outputs.
    modport master (
        output Fs, Fe, Fd, X0, One, Zero,
        input  Fs_ack, Fe_ack, Fd_ack, X0_ack, one_ack, zero_ack,
        input  Ch1_Up, Ch1_Down, Ch2_Up, Ch2_Down
    );

    // Decoder side.
    modport slave (
        input  Fs, Fe, Fd, X0, One, Zero,
        output Fs_ack, Fe_ack, Fd_ack, X0_ack, one_ack, zero_ack,
        output Ch1_Up, Ch1_Down, Ch2_Up, Ch2_Down
    );
endinterface

// File: rtl/output_decoder.sv
// Receive end of the symbol-serial control link. Each asynchronous request line
// is synchronized, a single 4-phase handshake engine serves the highest-priority
// pending request, and a frame FSM turns accepted symbols into Up/Down commands
// for two channels that are committed atomically on frame end.
module output_decoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    output_decoder_if.slave  bus
);

    // Request indices; a higher index means a higher priority.
    localparam int N_REQ = 6;
    localparam logic [2:0] IDX_ZERO = 3'd0;
    localparam logic [2:0] IDX_ONE  = 3'd1;
    localparam logic [2:0] IDX_X0   = 3'd2;
    localparam logic [2:0] IDX_FS   = 3'd3;
    localparam logic [2:0] IDX_FE   = 3'd4;
    localparam logic [2:0] IDX_FD   = 3'd5;

    // Channel staging/command encoding: {Up, Down}.
    localparam logic [1:0] CMD_UP   = 2'b10;
    localparam logic [1:0] CMD_DOWN = 2'b01;
    localparam logic [1:0] CMD_STOP = 2'b00;

    typedef enum logic {
        WAIT_REQ,
        HOLD
    } hs_state_t;

    typedef enum logic [1:0] {
        IDLE,
        CH1,
        CH2
    } frame_state_t;

    logic [N_REQ-1:0] req_raw;
    logic [N_REQ-1:0] req_sync;

    assign req_raw = {bus.Fd, bus.Fe, bus.Fs, bus.X0, bus.One, bus.Zero};

    // One synchronizer chain per request line; only the last stage is used.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;

            // Shift the raw request through SYNC_STAGES flops.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg[0] <= req_raw[gi];
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        sync_reg[s] <= sync_reg[s-1];
                    end
                end
            end

            assign req_sync[gi] = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic       pick_valid;
    logic [2:0] pick_idx;

    // Fixed-priority pick: scanning upward lets the highest pending index win.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_sync[i]) begin
                pick_valid = 1'b1;
                pick_idx   = 3'(i);
            end
        end
    end

    hs_state_t        hs_reg;
    frame_state_t     frame_reg;
    logic [2:0]       sel_reg;
    logic [N_REQ-1:0] ack_reg;
    logic [1:0]       stage1_reg;
    logic [1:0]       stage2_reg;
    logic [1:0]       ch1_reg;
    logic [1:0]       ch2_reg;

    // Handshake engine and frame FSM; the symbol action happens on the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_reg     <= WAIT_REQ;
            frame_reg  <= IDLE;
            sel_reg    <= 3'd0;
            ack_reg    <= '0;
            stage1_reg <= CMD_STOP;
            stage2_reg <= CMD_STOP;
            ch1_reg    <= CMD_STOP;
            ch2_reg    <= CMD_STOP;
        end else begin
            case (hs_reg)
                WAIT_REQ: begin
                    if (pick_valid) begin
                        ack_reg <= N_REQ'(1) << pick_idx;
                        sel_reg <= pick_idx;
                        hs_reg  <= HOLD;
                        case (pick_idx)
                            IDX_FD: begin
                                // Abort: staged data is dropped, outputs keep the last commit.
                                frame_reg <= IDLE;
                            end
                            IDX_FE: begin
                                // Commit only from inside a frame; a stray Fe in IDLE is ignored.
                                if (frame_reg != IDLE) begin
                                    ch1_reg   <= stage1_reg;
                                    ch2_reg   <= stage2_reg;
                                    frame_reg <= IDLE;
                                end
                            end
                            IDX_FS: begin
                                // Start or restart a frame with both channels at stop.
                                frame_reg  <= CH1;
                                stage1_reg <= CMD_STOP;
                                stage2_reg <= CMD_STOP;
                            end
                            IDX_X0: begin
                                if (frame_reg == CH1) begin
                                    frame_reg <= CH2;
                                end
                            end
                            IDX_ONE: begin
                                if (frame_reg == CH1) begin
                                    stage1_reg <= CMD_UP;
                                end else if (frame_reg == CH2) begin
                                    stage2_reg <= CMD_UP;
                                end
                            end
                            IDX_ZERO: begin
                                if (frame_reg == CH1) begin
                                    stage1_reg <= CMD_DOWN;
                                end else if (frame_reg == CH2) begin
                                    stage2_reg <= CMD_DOWN;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                HOLD: begin
                    // Release once the served request has been seen low.
                    if (!req_sync[sel_reg]) begin
                        ack_reg <= '0;
                        hs_reg  <= WAIT_REQ;
                    end
                end
                default: begin
                    hs_reg  <= WAIT_REQ;
                    ack_reg <= '0;
                end
            endcase
        end
    end

    assign bus.zero_ack = ack_reg[IDX_ZERO];
    assign bus.one_ack  = ack_reg[IDX_ONE];
    assign bus.X0_ack   = ack_reg[IDX_X0];
    assign bus.Fs_ack   = ack_reg[IDX_FS];
    assign bus.Fe_ack   = ack_reg[IDX_FE];
    assign bus.Fd_ack   = ack_reg[IDX_FD];

    assign bus.Ch1_Up   = ch1_reg[1];
    assign bus.Ch1_Down = ch1_reg[0];
    assign bus.Ch2_Up   = ch2_reg[1];
    assign bus.Ch2_Down = ch2_reg[0];

endmodule

// File: tb/tb_output_decoder.sv
// Directed bench for output_decoder: a table of symbol handshakes with the
// expected committed outputs after each, then hand-written corner sequences.
module tb_output_decoder;

    localparam int SYNC_STAGES = 2;
    localparam int LAT = SYNC_STAGES + 1;
    localparam int TIMEOUT = 20;

    // Request indices (bit positions in req/acks).
    localparam int ZERO = 0;
    localparam int ONE  = 1;
    localparam int X0   = 2;
    localparam int FS   = 3;
    localparam int FE   = 4;
    localparam int FD   = 5;

    logic clk = 1'b0;
    logic rst;
    logic [5:0] req;
    logic [5:0] acks;
    logic [3:0] outs;

    int n_vec = 0;
    int n_err = 0;

    output_decoder_if bus ();

    output_decoder #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.Zero = req[ZERO];
    assign bus.One  = req[ONE];
    assign bus.X0   = req[X0];
    assign bus.Fs   = req[FS];
    assign bus.Fe   = req[FE];
    assign bus.Fd   = req[FD];

    assign acks = {bus.Fd_ack, bus.Fe_ack, bus.Fs_ack, bus.X0_ack, bus.one_ack, bus.zero_ack};
    assign outs = {bus.Ch1_Up, bus.Ch1_Down, bus.Ch2_Up, bus.Ch2_Down};

    always #5 clk = ~clk;

    typedef struct {
        int         sym;
        logic [3:0] exp_out;
    } vec_t;

    string sym_name [6] = '{"Zero", "One", "X0", "Fs", "Fe", "Fd"};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Never more than one ack high at once.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_vec++;
            if (!$onehot0(acks)) begin
                n_err++;
                $display("FAIL ack_onehot: got %b, expected at most one bit set", acks);
            end
        end
    end

    // Raise request idx (if not already high) and wait for its ack; checks the
    // latency, which ack rose, that outputs did not change early, and the outputs
    // at the accept edge.
    task automatic raise(input int idx, input int lat, input logic [3:0] prev, input logic [3:0] exp);
        int  n;
        bit  got;
        bit  early;
        n = 0;
        got = 0;
        early = 0;
        req[idx] = 1'b1;
        while (!got && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
            if (acks != 6'b0) got = 1;
            else if (outs !== prev) early = 1;
        end
        if (!got) begin
            check({sym_name[idx], " ack timeout"}, 8'(n), 8'(lat));
            return;
        end
        check({sym_name[idx], " ack rise latency"}, 8'(n), 8'(lat));
        check({sym_name[idx], " ack select"}, {2'b0, acks}, 8'(6'b1 << idx));
        check({sym_name[idx], " outputs early change"}, {7'b0, early}, 8'd0);
        check({sym_name[idx], " outputs at accept"}, {4'b0, outs}, {4'b0, exp});
        $display("sym %-4s acked after %0d clk, outs=%b", sym_name[idx], n, outs);
    endtask

    // Drop request idx and wait for its ack to fall.
    task automatic drop(input int idx);
        int n;
        n = 0;
        req[idx] = 1'b0;
        while (acks[idx] && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({sym_name[idx], " ack fall latency"}, 8'(n), 8'(LAT));
    endtask

    task automatic symbol(input int idx, input logic [3:0] prev, input logic [3:0] exp);
        raise(idx, LAT, prev, exp);
        drop(idx);
    endtask

    vec_t vecs [26];
    logic [3:0] prev;

    initial begin
        vecs = '{
            '{FS, 4'b0000}, '{ONE, 4'b0000}, '{X0, 4'b0000}, '{ZERO, 4'b0000}, '{FE, 4'b1001},
            '{FS, 4'b1001}, '{ZERO, 4'b1001}, '{FE, 4'b0100},
            '{FS, 4'b0100}, '{ONE, 4'b0100}, '{X0, 4'b0100}, '{ONE, 4'b0100}, '{FD, 4'b0100},
            '{ONE, 4'b0100}, '{FE, 4'b0100}, '{X0, 4'b0100},
            '{FS, 4'b0100}, '{X0, 4'b0100}, '{ONE, 4'b0100}, '{FE, 4'b0010},
            '{FS, 4'b0010}, '{ONE, 4'b0010}, '{ZERO, 4'b0010}, '{FE, 4'b0100},
            '{FS, 4'b0100}, '{ONE, 4'b0100}
        };

        // Reset
        req = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", {4'b0, outs}, 8'd0);
        check("reset acks", {2'b0, acks}, 8'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle outs", {4'b0, outs}, 8'd0);
        check("idle acks", {2'b0, acks}, 8'd0);

        // Table of symbols
        prev = 4'b0000;
        foreach (vecs[i]) begin
            symbol(vecs[i].sym, prev, vecs[i].exp_out);
            prev = vecs[i].exp_out;
        end
        // Restart inside frame (Fs after One) then commit: both channels stop.
        symbol(FS, prev, prev);
        symbol(FE, prev, 4'b0000);
        prev = 4'b0000;

        // Fe and One raised together in CH1: Fe wins, One then acked in IDLE.
        symbol(FS, prev, prev);
        symbol(ONE, prev, prev);
        req[ONE] = 1'b1;
        raise(FE, LAT, prev, 4'b1000);
        check("one_ack held off by Fe", {7'b0, bus.one_ack}, 8'd0);
        drop(FE);
        raise(ONE, 1, 4'b1000, 4'b1000);
        drop(ONE);
        prev = 4'b1000;

        // Reset mid-frame with One ack still high.
        symbol(FS, prev, prev);
        raise(ONE, LAT, prev, prev);
        req[ONE] = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midframe reset outs", {4'b0, outs}, 8'd0);
        check("midframe reset acks", {2'b0, acks}, 8'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        prev = 4'b0000;
        symbol(FE, prev, 4'b0000);
        symbol(FS, prev, prev);
        symbol(ONE, prev, prev);
        symbol(FE, prev, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
